// File: rtl/dvsdcls_sub_seq_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// The master drives the operands and accepts the result; the slave is the datapath.
interface dvsdcls_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/dvsdcls_sub_seq.sv
// Multi-cycle a - b - bin subtractor: one 4-bit borrow-lookahead slice per clock,
// valid/ready handshake on both operand and result sides.
module dvsdcls_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dvsdcls_sub_seq_if.slave  bus
);
    localparam int N   = WIDTH / 4;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] diff_q;
    logic [KW-1:0]    k_q;
    logic             br_q;
    logic             bout_q;
    logic             ovf_q;

    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_d;
    logic [4:0]       sl_br;
    logic             last_slice;

    // Flat two-level borrow lookahead: every borrow is a direct SOP of g/p/br0.
    function automatic logic [4:0] borrow_lookahead(input logic [3:0] x,
                                                    input logic [3:0] y,
                                                    input logic       b0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] br;
        g     = ~x & y;
        p     = ~(x ^ y);
        br[0] = b0;
        br[1] = g[0] | (p[0] & b0);
        br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & b0);
        br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & b0);
        br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & b0);
        return br;
    endfunction

    always_comb begin
        sl_a       = a_q[int'(k_q) * 4 +: 4];
        sl_b       = b_q[int'(k_q) * 4 +: 4];
        sl_br      = borrow_lookahead(sl_a, sl_b, br_q);
        sl_d       = sl_a ^ sl_b ^ sl_br[3:0];
        res_d      = res_q;
        res_d[int'(k_q) * 4 +: 4] = sl_d;
        last_slice = (k_q == KW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            br_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        br_q    <= bus.bin;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    br_q  <= sl_br[4];
                    k_q   <= k_q + 1'b1;
                    // Result registers only move here, so they hold through IDLE/RUN.
                    if (last_slice) begin
                        diff_q  <= res_d;
                        bout_q  <= sl_br[4];
                        ovf_q   <= (a_q[MSB] != b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_dvsdcls_sub_seq.sv
// Bench for the sequential subtractor: fixed vector table, hand-written
// handshake/reset sequences and random operands against an arithmetic model.
module tb_dvsdcls_sub_seq;
    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dvsdcls_sub_seq_if #(.WIDTH(W)) bus ();
    dvsdcls_sub_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unsigned result gives diff and borrow; signed range check gives overflow.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        longint ur;
        longint sr;
        logic   bo;
        logic   ov;
        ur = longint'(a) - longint'(b) - longint'(bin);
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        bo = (ur < 0);
        ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
        return {ov, bo, W'(ur)};
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, bus.out_valid, 0);
        check({tag, "_post_ready"}, bus.in_ready, 1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic bin, input logic [W-1:0] d, input logic bo,
                           input logic ov, input int hold);
        int lat;
        check({tag, "_idle_ready"}, bus.in_ready, 1);
        start_op(a, b, bin);
        check({tag, "_acc_ready"}, bus.in_ready, 0);
        wait_result(lat);
        check({tag, "_latency"}, lat, LAT);
        repeat (hold) tick();
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_diff"}, bus.diff, d);
        check({tag, "_bout"}, bus.bout, bo);
        check({tag, "_ovf"}, bus.ovf, ov);
        handoff(tag);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rbin;
        logic [W+1:0] exp;
        int           lat;
        logic         seen;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_ready", bus.in_ready, 1);
        check("rst_diff", bus.diff, 0);
        check("rst_bout", bus.bout, 0);
        check("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        tick();
        check("rel_ready", bus.in_ready, 1);

        // Asynchronous clear while a result is held, without a clock edge.
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_result(lat);
        check("async_pre_diff", bus.diff, 16'h1000);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", bus.out_valid, 0);
        check("async_ready", bus.in_ready, 1);
        check("async_diff", bus.diff, 0);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            full_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                    vecs[i].d, vecs[i].bo, vecs[i].ov, 0);
        end

        // Backpressure: result held, inputs churn, nothing may move.
        start_op(16'h1234, 16'h0234, 1'b0);
        wait_result(lat);
        check("bp_latency", lat, LAT);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.bin      = 1'($urandom_range(0, 1));
            tick();
            check("bp_valid", bus.out_valid, 1);
            check("bp_diff", bus.diff, 16'h1000);
            check("bp_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b1;
        bus.a         = 16'h00F0;
        bus.b         = 16'h000F;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_hand_valid", bus.out_valid, 0);
        check("bp_hand_ready", bus.in_ready, 1);
        tick();
        check("bp_next_acc", bus.in_ready, 0);
        bus.a = 16'hAAAA;
        wait_result(lat);
        bus.in_valid = 1'b0;
        check("bp_next_lat", lat, LAT);
        check("bp_next_diff", bus.diff, 16'h00E1);
        check("bp_next_bout", bus.bout, 0);
        handoff("bp_next");

        // Reset two edges into RUN: the operation must vanish.
        start_op(16'h0000, 16'h0001, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun_ready", bus.in_ready, 1);
        check("midrun_valid", bus.out_valid, 0);
        check("midrun_diff", bus.diff, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrun_no_valid", seen, 0);
        full_op("fresh", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = ra;
            exp  = model(ra, rb, rbin);
            full_op($sformatf("rnd%0d", i), ra, rb, rbin, exp[W-1:0], exp[W], exp[W+1],
                    $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
